// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared word-size constants, the fetch-stage state encoding and
//             a small PC increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int                WORD_W      = 32;
    localparam logic [WORD_W-1:0] INSTR_BYTES = 32'd4;
    localparam int                ENTRY_W     = 2 * WORD_W;   // {instr, pc}

    // Fetch-stage states.
    // FETCH: requesting from memory.
    // FULL:  skid buffer holds two entries.
    // FAULT: sticky error; only reset leaves this state.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        FAULT = 2'd2
    } if_state_t;

    // Address of the next sequential instruction. The 32-bit sum wraps
    // naturally, so 0xFFFFFFFC is followed by 0x00000000.
    function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : if_skid_buf
//  Brief    : Two-entry FIFO holding fetched {instr, pc} pairs in front of
//             decode. Push and pop in one cycle are both honoured. Flush
//             empties the buffer and takes priority over push and pop.
//  Revision : 1.0 - initial release
// ============================================================================
module if_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full  = (r_count == 2'd2);
    assign w_empty = (r_count == 2'd0);

    // A pop from a full buffer frees the slot that the write pointer
    // targets, so a simultaneous push is still safe.
    assign w_do_push = push && (!w_full || pop);
    assign w_do_pop  = pop && !w_empty;

    // Storage and pointer update; flush only resets the pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule : if_skid_buf
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Brief    : Instruction-fetch stage. Owns the fetch PC, issues one word
//             request per cycle to instruction memory, queues returned
//             words in a two-entry skid buffer and hands them to decode
//             over valid/ready. Redirects flush the buffer and restart
//             fetch. A misaligned redirect target parks the stage in a
//             sticky fault until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] START_ADDR = 32'h0000_0000
)
(
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_addr,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc4,
    output logic              fault
);

    if_state_t          r_state;
    logic [WORD_W-1:0]  r_pc;
    logic               r_imem_req;
    logic               r_fault;

    // Last values shown to decode, so the id_* outputs hold steady (and
    // read as zero after reset) whenever the buffer is empty.
    logic [WORD_W-1:0]  r_hold_instr;
    logic [WORD_W-1:0]  r_hold_pc;
    logic [WORD_W-1:0]  r_hold_pc4;

    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_misaligned;
    logic [1:0]         w_count;
    logic [1:0]         w_next_count;
    logic [ENTRY_W-1:0] w_head;
    logic [WORD_W-1:0]  w_head_instr;
    logic [WORD_W-1:0]  w_head_pc;
    logic [WORD_W-1:0]  w_head_pc4;
    logic               w_valid;

    // A redirect discards a same-cycle ack and a same-cycle pop. Decode
    // owns an instruction it took while redirecting.
    assign w_push       = r_imem_req && imem_ack && !redirect;
    assign w_pop        = w_valid && id_ready && !redirect;
    assign w_flush      = redirect && (r_state != FAULT);
    assign w_misaligned = (redirect_addr[1:0] != 2'b00);
    assign w_next_count = w_count + {1'b0, w_push} - {1'b0, w_pop};

    if_skid_buf u_skid_buf (
        .clk       (clk),
        .rst       (reset),
        .push      (w_push),
        .push_data ({imem_rdata, r_pc}),
        .pop       (w_pop),
        .flush     (w_flush),
        .count     (w_count),
        .head      (w_head)
    );

    assign w_head_instr = w_head[ENTRY_W-1:WORD_W];
    assign w_head_pc    = w_head[WORD_W-1:0];
    assign w_head_pc4   = next_word_addr(w_head_pc);
    assign w_valid      = (w_count != 2'd0) && (r_state != FAULT);

    // Fetch FSM with the PC and registered request/fault outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= START_ADDR;
            r_imem_req <= 1'b1;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                FAULT: begin
                    r_imem_req <= 1'b0;
                    r_fault    <= 1'b1;
                end
                default: begin
                    if (redirect) begin
                        if (w_misaligned) begin
                            r_state    <= FAULT;
                            r_imem_req <= 1'b0;
                            r_fault    <= 1'b1;
                        end else begin
                            r_state    <= FETCH;
                            r_pc       <= redirect_addr;
                            r_imem_req <= 1'b1;
                        end
                    end else begin
                        if (w_push) begin
                            r_pc <= next_word_addr(r_pc);
                        end
                        if (w_next_count == 2'd2) begin
                            r_state    <= FULL;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state    <= FETCH;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Remember the most recently presented head for the idle-hold behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_hold_pc4   <= '0;
        end else if (w_valid) begin
            r_hold_instr <= w_head_instr;
            r_hold_pc    <= w_head_pc;
            r_hold_pc4   <= w_head_pc4;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign fault     = r_fault;
    assign id_valid  = w_valid;
    assign id_instr  = w_valid ? w_head_instr : r_hold_instr;
    assign id_pc     = w_valid ? w_head_pc    : r_hold_pc;
    assign id_pc4    = w_valid ? w_head_pc4   : r_hold_pc4;

endmodule : if_stage
`default_nettype wire
